// File: rtl/crv32_mem_arbiter_if.sv
// rtl/crv32_mem_arbiter_if.sv - valid/ready memory bus shared by CPU, debug and memory ports
// The master drives the request fields; the slave answers with ready/rdata.
interface crv32_mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              ready;
  logic [31:0]       rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/crv32_mem_arbiter.sv
// rtl/crv32_mem_arbiter.sv - CPU/debug arbiter for the single memory port
// Fixed debug priority, registered grant, per-transaction timeout with error pulse.
module crv32_mem_arbiter #(
  parameter int          ADDR_W    = 32,
  parameter int          TIMEOUT   = 15,
  parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
  input  logic                CLK,
  input  logic                RESET,
  crv32_mem_arbiter_if.slave  cpu,
  crv32_mem_arbiter_if.slave  dbg,
  crv32_mem_arbiter_if.master mem,
  output logic [1:0]          owner,
  output logic                timeout_err
);

  localparam int              CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);
  localparam bit              TO_EN  = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_XFER = 2'd1,
    DBG_XFER = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               mem_valid_q, mem_valid_d;
  logic [1:0]         owner_q, owner_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic timeout_hit;
  logic done;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      owner_q     <= 2'b00;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      cnt_q       <= cnt_d;
    end
  end

  // A ready from memory in the limit cycle takes precedence over the timeout.
  assign timeout_hit = TO_EN && (state_q != IDLE) && (cnt_q == TO_LIM) && !mem.ready;
  assign done        = (state_q != IDLE) && (mem.ready || timeout_hit);

  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (dbg.valid) begin
          state_d     = DBG_XFER;
          mem_valid_d = 1'b1;
          owner_d     = 2'b10;
          addr_d      = dbg.addr;
          wdata_d     = dbg.wdata;
          wstrb_d     = dbg.wstrb;
          cnt_d       = '0;
        end else if (cpu.valid) begin
          state_d     = CPU_XFER;
          mem_valid_d = 1'b1;
          owner_d     = 2'b01;
          addr_d      = cpu.addr;
          wdata_d     = cpu.wdata;
          wstrb_d     = cpu.wstrb;
          cnt_d       = '0;
        end
      end
      CPU_XFER, DBG_XFER: begin
        if (done) begin
          state_d     = IDLE;
          mem_valid_d = 1'b0;
          owner_d     = 2'b00;
        end else if (TO_EN && cnt_q != TO_LIM) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        mem_valid_d = 1'b0;
        owner_d     = 2'b00;
      end
    endcase
  end

  assign mem.valid = mem_valid_q;
  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_q;
  assign mem.wstrb = wstrb_q;

  assign cpu.ready = done && (state_q == CPU_XFER);
  assign dbg.ready = done && (state_q == DBG_XFER);
  assign cpu.rdata = cpu.ready ? (timeout_hit ? ERR_RDATA : mem.rdata) : 32'h0;
  assign dbg.rdata = dbg.ready ? (timeout_hit ? ERR_RDATA : mem.rdata) : 32'h0;

  assign owner       = owner_q;
  assign timeout_err = timeout_hit;

endmodule
